cfg_bitstream_serializer: RTL and testbench
===========================================

Name: cfg_bitstream_serializer

Overview:
- Converts 32-bit configuration words written by the RISC-V core into the serial programming stream for the embedded fabric config chain.
- Drives programming_clock, head, pReset and set.
- Sits between the core's memory-mapped peripheral bus and the fabric's shift chain; the fabric shifts head on programming_clock rising edge.

Parameters:
- CLK_DIV, 2, clk cycles per programming_clock half-period (min 2).
- FIFO_DEPTH, 4, word buffer depth (power of 2).
- PRESET_CYCLES, 8, clk cycles pReset is held high before shifting.
- SET_CYCLES, 4, clk cycles set is held high after the last bit.
- CNT_W, 24, width of bit-count input.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse; begins a programming session (ignored unless IDLE)
- abort  in  1  one-cycle pulse; cancels the session
- bit_count  in  CNT_W  total bits to shift; sampled on start
- wr_valid  in  1  word write strobe
- wr_data  in  32  config word
- wr_ready  out  1  FIFO not full
- programming_clock  out  1  serial shift clock to the fabric
- head  out  1  serial data to the fabric
- pReset  out  1  chain reset pulse
- set  out  1  configuration latch pulse
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on completion

Behaviour:
- Reset values: programming_clock=0, head=0, pReset=0, set=0, busy=0, done=0; FIFO empty (wr_ready=1); FSM=IDLE.
- Write handshake: a word is accepted when wr_valid && wr_ready. Writes are legal in any state, including before start. A write while full is dropped.
- FSM states: IDLE, PRESET, LOAD, SHIFT, SET, DONE.
- IDLE:
  - On start with bit_count==0: go to SET directly.
  - On start otherwise: latch remaining=bit_count and go to PRESET.
- PRESET: pReset=1 for exactly PRESET_CYCLES cycles, then LOAD.
- LOAD:
  - FIFO non-empty: pop into a 32-bit shift register, bit index 31, go to SHIFT.
  - FIFO empty: stall in LOAD. programming_clock stays low and head holds its value.
- SHIFT, one bit slot = 2*CLK_DIV clk cycles, with programming_clock low at slot start:
  - Slot cycle 1: head <= shreg[31] (MSB first).
  - Slot cycle CLK_DIV: programming_clock rises.
  - Slot cycle 2*CLK_DIV: programming_clock falls; remaining decrements and the shift register shifts left.
  - Consequence: head is stable across both the rising and the falling edge.
- After each slot:
  - If remaining==0: go to SET; unused bits of a partial final word are discarded.
  - Else if 32 bits of the word have been consumed: go to LOAD.
  - Else: next slot.
- SET: set=1 for exactly SET_CYCLES cycles, then DONE.
- DONE: done=1 for one cycle, then IDLE. head returns to 0 in IDLE.
- abort (any state except IDLE):
  - Next cycle: FSM=IDLE, programming_clock=0, head=0, pReset=0, set=0; FIFO flushed.
  - No done pulse is produced.
- Simultaneous start and abort in IDLE: abort wins; start is ignored.
- Asynchronous reset mid-session: all outputs go to reset values immediately; the session is lost.
- Bitstream over-supply: words left in the FIFO after completion remain for the next session.
- Latency: the first programming_clock rising edge occurs PRESET_CYCLES+1(LOAD)+CLK_DIV cycles after start, given a non-empty FIFO.
- Counter widths: remaining is CNT_W bits and never wraps (stops at 0); the bit index is 5 bits.

Decomposition:
- Package cfg_ser_pkg holds:
  - the state enum;
  - the WORD_W=32 constant;
  - the default CLK_DIV, PRESET_CYCLES and SET_CYCLES localparams.
- One sub-module, cfg_word_fifo:
  - synchronous FIFO, FIFO_DEPTH x 32, with push, pop, flush, full and empty;
  - first-word-fall-through read.
- The FSM, divider and shift register live in cfg_bitstream_serializer.

Test Plan:
1. Write 0xA5000000, start with bit_count=8, CLK_DIV=2 -> pReset high 8 cycles; head at 8 programming_clock negedges = 1,0,1,0,0,1,0,1; set high 4 cycles; done pulse once; busy low afterwards.
2. Write 0xFFFFFFFF and 0x00000001, bit_count=64 -> 64 rising edges; first 32 head=1, next 31 head=0, last head=1; one LOAD cycle between words with programming_clock held low.
3. Start with empty FIFO, bit_count=4, write 0x90000000 after 50 cycles -> programming_clock stays low during the stall; head sequence then 1,0,0,1.
4. Write 5 words back-to-back in IDLE -> wr_ready low after the 4th; 5th word dropped; FIFO holds the first 4.
5. Abort during bit 10 of a 32-bit session -> next cycle programming_clock=0, head=0, busy=0; no set or done pulse; wr_ready=1 (FIFO flushed).
6. start with bit_count=0 -> no pReset and no programming_clock edges; set high 4 cycles; done pulse. Assert rst low mid-SHIFT -> outputs zero immediately.

Source files
------------

// File: rtl/cfg_ser_pkg.sv
// +----------------------------------------------------------------------------
// | cfg_ser_pkg : shared types and defaults for the config bitstream serializer
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package cfg_ser_pkg;

  localparam int WORD_W            = 32;
  localparam int DEF_CLK_DIV       = 2;
  localparam int DEF_PRESET_CYCLES = 8;
  localparam int DEF_SET_CYCLES    = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESET = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_SET    = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/cfg_bitstream_serializer_if.sv
// +----------------------------------------------------------------------------
// | cfg_bitstream_serializer_if : core-side control/write bus and fabric outputs
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface cfg_bitstream_serializer_if #(
  parameter int CNT_W = 24
);
  import cfg_ser_pkg::*;

  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  bit_count;
  logic              wr_valid;
  logic [WORD_W-1:0] wr_data;
  logic              wr_ready;
  logic              programming_clock;
  logic              head;
  logic              pReset;
  logic              set;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, bit_count, wr_valid, wr_data,
    input  wr_ready, programming_clock, head, pReset, set, busy, done
  );

  modport slave (
    input  start, abort, bit_count, wr_valid, wr_data,
    output wr_ready, programming_clock, head, pReset, set, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/cfg_word_fifo.sv
// +----------------------------------------------------------------------------
// | cfg_word_fifo : synchronous first-word-fall-through word FIFO with flush
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module cfg_word_fifo
  import cfg_ser_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = WORD_W
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         push_i,
  input  wire logic [W-1:0] wr_data_i,
  input  wire logic         pop_i,
  input  wire logic         flush_i,
  output logic [W-1:0]      rd_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push   = push_i && !full_o && !flush_i;
  assign do_pop    = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cfg_bitstream_serializer.sv
// +----------------------------------------------------------------------------
// | cfg_bitstream_serializer : turns buffered 32-bit config words into the
// | fabric's serial programming stream (programming_clock/head/pReset/set)
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module cfg_bitstream_serializer
  import cfg_ser_pkg::*;
#(
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int FIFO_DEPTH    = 4,
  parameter int PRESET_CYCLES = DEF_PRESET_CYCLES,
  parameter int SET_CYCLES    = DEF_SET_CYCLES,
  parameter int CNT_W         = 24
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  cfg_bitstream_serializer_if.slave  bus
);

  localparam logic [15:0] C_RISE_AT     = 16'(CLK_DIV - 1);
  localparam logic [15:0] C_SLOT_LAST   = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] C_PRESET_LAST = 16'(PRESET_CYCLES - 1);
  localparam logic [15:0] C_SET_LAST    = 16'(SET_CYCLES - 1);

  state_e            state_q;
  logic [15:0]       cnt_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [CNT_W-1:0]  remaining_d;
  logic [4:0]        bit_idx_q;
  logic [WORD_W-1:0] shreg_q;
  logic              pclk_q;
  logic              head_q;
  logic              preset_q;
  logic              set_q;
  logic              busy_q;
  logic              done_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_rd_data;

  assign fifo_flush  = bus.abort && (state_q != ST_IDLE);
  assign fifo_push   = bus.wr_valid && !fifo_full;
  assign fifo_pop    = (state_q == ST_LOAD) && !fifo_empty && !bus.abort;
  assign remaining_d = (remaining_q == '0) ? '0 : remaining_q - CNT_W'(1);

  cfg_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (fifo_push),
    .wr_data_i (bus.wr_data),
    .pop_i     (fifo_pop),
    .flush_i   (fifo_flush),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      remaining_q <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      pclk_q      <= 1'b0;
      head_q      <= 1'b0;
      preset_q    <= 1'b0;
      set_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          head_q <= 1'b0;
          if (bus.start && !bus.abort) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            if (bus.bit_count == '0) begin
              state_q <= ST_SET;
              set_q   <= 1'b1;
            end else begin
              remaining_q <= bus.bit_count;
              state_q     <= ST_PRESET;
              preset_q    <= 1'b1;
            end
          end
        end

        ST_PRESET: begin
          if (cnt_q == C_PRESET_LAST) begin
            preset_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= ST_LOAD;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        // Stalls here with programming_clock low until a word is available.
        ST_LOAD: begin
          if (fifo_pop) begin
            shreg_q   <= fifo_rd_data;
            bit_idx_q <= 5'd31;
            cnt_q     <= '0;
            state_q   <= ST_SHIFT;
          end
        end

        // head changes only at slot start, so it is stable over both edges.
        ST_SHIFT: begin
          if (cnt_q == 16'd0) begin
            head_q <= shreg_q[WORD_W-1];
          end
          if (cnt_q == C_RISE_AT) begin
            pclk_q <= 1'b1;
          end
          if (cnt_q == C_SLOT_LAST) begin
            pclk_q      <= 1'b0;
            cnt_q       <= '0;
            shreg_q     <= {shreg_q[WORD_W-2:0], 1'b0};
            remaining_q <= remaining_d;
            if (remaining_d == '0) begin
              state_q <= ST_SET;
              set_q   <= 1'b1;
            end else if (bit_idx_q == 5'd0) begin
              state_q <= ST_LOAD;
            end else begin
              bit_idx_q <= bit_idx_q - 5'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        ST_SET: begin
          if (cnt_q == C_SET_LAST) begin
            set_q   <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          head_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (fifo_flush) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        pclk_q   <= 1'b0;
        head_q   <= 1'b0;
        preset_q <= 1'b0;
        set_q    <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
      end
    end
  end

  assign bus.wr_ready          = !fifo_full;
  assign bus.programming_clock = pclk_q;
  assign bus.head              = head_q;
  assign bus.pReset            = preset_q;
  assign bus.set               = set_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;

endmodule

`default_nettype wire

// File: tb/tb_cfg_bitstream_serializer.sv
// +----------------------------------------------------------------------------
// | tb_cfg_bitstream_serializer : directed table-driven bench for the serializer
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_cfg_bitstream_serializer;

  localparam int CLK_DIV = 2;

  logic clk;
  logic rst_n;

  cfg_bitstream_serializer_if #(.CNT_W(24)) bus ();

  cfg_bitstream_serializer #(
    .CLK_DIV       (CLK_DIV),
    .FIFO_DEPTH    (4),
    .PRESET_CYCLES (8),
    .SET_CYCLES    (4),
    .CNT_W         (24)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          nw;
    int          bc;
    int          stall;
    logic [31:0] sw;
    logic [63:0] exp_bits;
    int          exp_rises;
    int          exp_preset;
    int          exp_set;
    int          exp_lat;
    int          exp_loads;
  } vec_t;

  vec_t vecs[7];

  int total = 0;
  int bad   = 0;

  int r_rises, r_preset, r_set, r_done, r_first, r_gap3, r_badgap, r_unstable;
  logic [127:0] got;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  // Runs one session from start to the done pulse (or budget), recording edges.
  task automatic run_session(input int bc, input int stall, input logic [31:0] sw, input int budget);
    logic prev_pclk;
    logic rise_head;
    int   last_fall;
    int   cyc;
    int   gap;
    r_rises = 0; r_preset = 0; r_set = 0; r_done = 0; r_first = 0;
    r_gap3 = 0; r_badgap = 0; r_unstable = 0; got = '0;
    prev_pclk = 1'b0; rise_head = 1'b0; last_fall = -1;
    bus.start     = 1'b1;
    bus.bit_count = 24'(bc);
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (1) begin
      if (bus.pReset) r_preset++;
      if (bus.set)    r_set++;
      if (bus.done)   r_done++;
      if (bus.programming_clock && !prev_pclk) begin
        r_rises++;
        rise_head = bus.head;
        if (r_rises == 1) r_first = cyc;
        if (last_fall >= 0) begin
          gap = cyc - last_fall;
          if (gap == CLK_DIV + 1) r_gap3++;
          else if (gap != CLK_DIV) r_badgap++;
        end
      end
      if (!bus.programming_clock && prev_pclk) begin
        got = {got[126:0], bus.head};
        if (bus.head !== rise_head) r_unstable++;
        last_fall = cyc;
      end
      prev_pclk = bus.programming_clock;
      if (bus.done || cyc >= budget) break;
      bus.wr_valid = (stall != 0 && cyc == stall);
      bus.wr_data  = sw;
      tick();
      cyc++;
    end
    bus.wr_valid = 1'b0;
  endtask

  // With an empty FIFO a session must park in LOAD without clocking the fabric.
  task automatic expect_stall(input string nm);
    int rises;
    logic prev;
    rises = 0;
    prev  = 1'b0;
    bus.start     = 1'b1;
    bus.bit_count = 24'd1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (bus.programming_clock && !prev) rises++;
      prev = bus.programming_clock;
      tick();
    end
    chk({nm, " stall rises"}, rises, 0);
    chk({nm, " stall busy"}, bus.busy, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk({nm, " stall abort busy"}, bus.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] fw [5];
    logic [63:0] mask;
    int          n;
    int          cnt_a;
    int          cnt_b;
    logic        prev;

    //               w0            w1            nw bc  stall sw            exp_bits                rises pre set lat loads
    vecs[0] = '{32'hA500_0000, 32'h0,        1, 8,  0,  32'h0,        64'hA5,                 8,   8,  4,  11, 0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 2, 64, 0,  32'h0,        64'hFFFF_FFFF_0000_0001, 64,  8,  4,  11, 1};
    vecs[2] = '{32'h1234_5678, 32'h0,        1, 32, 0,  32'h0,        64'h1234_5678,          32,  8,  4,  11, 0};
    vecs[3] = '{32'h0,         32'h0,        0, 0,  0,  32'h0,        64'h0,                  0,   0,  4,  0,  0};
    vecs[4] = '{32'hF000_0000, 32'h3C00_0000, 2, 4,  0,  32'h0,        64'hF,                  4,   8,  4,  11, 0};
    vecs[5] = '{32'h0,         32'h0,        0, 8,  0,  32'h0,        64'h3C,                 8,   8,  4,  11, 0};
    vecs[6] = '{32'h0,         32'h0,        0, 4,  50, 32'h9000_0000, 64'h9,                  4,   8,  4,  54, 0};

    bus.start = 1'b0; bus.abort = 1'b0; bus.bit_count = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0;
    rst_n = 1'b0;
    tick(); tick();
    chk("reset pclk",     bus.programming_clock, 0);
    chk("reset head",     bus.head, 0);
    chk("reset pReset",   bus.pReset, 0);
    chk("reset set",      bus.set, 0);
    chk("reset busy",     bus.busy, 0);
    chk("reset done",     bus.done, 0);
    chk("reset wr_ready", bus.wr_ready, 1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].nw > 0) write_word(vecs[i].w0);
      if (vecs[i].nw > 1) write_word(vecs[i].w1);
      run_session(vecs[i].bc, vecs[i].stall, vecs[i].sw, 1000);
      chk($sformatf("v%0d rises", i),     r_rises,    vecs[i].exp_rises);
      chk($sformatf("v%0d pReset", i),    r_preset,   vecs[i].exp_preset);
      chk($sformatf("v%0d set", i),       r_set,      vecs[i].exp_set);
      chk($sformatf("v%0d done", i),      r_done,     1);
      chk($sformatf("v%0d latency", i),   r_first,    vecs[i].exp_lat);
      chk($sformatf("v%0d loadgaps", i),  r_gap3,     vecs[i].exp_loads);
      chk($sformatf("v%0d badgaps", i),   r_badgap,   0);
      chk($sformatf("v%0d unstable", i),  r_unstable, 0);
      if (vecs[i].bc != 0) begin
        mask = (vecs[i].bc >= 64) ? '1 : ((64'd1 << vecs[i].bc) - 64'd1);
        chk($sformatf("v%0d bits", i), got[63:0] & mask, vecs[i].exp_bits);
      end
      tick();
      chk($sformatf("v%0d busy after", i), bus.busy, 0);
      chk($sformatf("v%0d head after", i), bus.head, 0);
      chk($sformatf("v%0d done after", i), bus.done, 0);
      repeat (3) tick();
    end

    // FIFO capacity: fifth back-to-back word is dropped.
    fw[0] = 32'hDEAD_BEEF; fw[1] = 32'h0123_4567; fw[2] = 32'h89AB_CDEF;
    fw[3] = 32'hCAFE_F00D; fw[4] = 32'h5555_AAAA;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("full wr_ready before w%0d", k), bus.wr_ready, (k < 4) ? 1 : 0);
      write_word(fw[k]);
    end
    chk("full wr_ready after", bus.wr_ready, 0);
    run_session(128, 0, 32'h0, 1000);
    chk("full bits", got, {fw[0], fw[1], fw[2], fw[3]});
    chk("full done", r_done, 1);
    tick(); tick();
    expect_stall("drop5");
    repeat (3) tick();

    // Abort during bit 10 of a 32-bit session; the second word must be flushed.
    write_word(32'hFFFF_FFFF);
    write_word(32'h1111_1111);
    bus.start = 1'b1; bus.bit_count = 24'd32;
    tick();
    bus.start = 1'b0;
    cnt_a = 0; prev = 1'b0; n = 0;
    while (cnt_a < 10 && n < 300) begin
      if (bus.programming_clock && !prev) cnt_a++;
      prev = bus.programming_clock;
      if (cnt_a < 10) begin tick(); n++; end
    end
    chk("abort reached bit10", cnt_a, 10);
    chk("abort head before", bus.head, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort pclk",     bus.programming_clock, 0);
    chk("abort head",     bus.head, 0);
    chk("abort busy",     bus.busy, 0);
    chk("abort wr_ready", bus.wr_ready, 1);
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.set)  cnt_a++;
      if (bus.done) cnt_b++;
      tick();
    end
    chk("abort no set",  cnt_a, 0);
    chk("abort no done", cnt_b, 0);
    expect_stall("flush");
    repeat (3) tick();

    // Simultaneous start and abort in IDLE: abort wins, word stays buffered.
    write_word(32'hFFFF_FFFF);
    bus.start = 1'b1; bus.abort = 1'b1; bus.bit_count = 24'd8;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("startabort busy", bus.busy, 0);
    cnt_a = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.pReset) cnt_a++;
      tick();
    end
    chk("startabort no pReset", cnt_a, 0);

    // Asynchronous reset in the middle of shifting.
    bus.start = 1'b1; bus.bit_count = 24'd32;
    tick();
    bus.start = 1'b0;
    cnt_a = 0; prev = 1'b0; n = 0;
    while (cnt_a < 3 && n < 200) begin
      if (bus.programming_clock && !prev) cnt_a++;
      prev = bus.programming_clock;
      if (cnt_a < 3) begin tick(); n++; end
    end
    chk("rst reached bit3", cnt_a, 3);
    chk("rst pclk before", bus.programming_clock, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst pclk",     bus.programming_clock, 0);
    chk("rst head",     bus.head, 0);
    chk("rst busy",     bus.busy, 0);
    chk("rst pReset",   bus.pReset, 0);
    chk("rst set",      bus.set, 0);
    chk("rst done",     bus.done, 0);
    chk("rst wr_ready", bus.wr_ready, 1);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("rst busy after", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
